// File: rtl/timeslot_event_scheduler.sv
// Timestep-slotted event scheduler: one circular queue per future timestep,
// all queues sharing one RAM addressed as {slot, pointer}. Events are pushed
// with a relative delay, popped from the current slot, and whatever is left
// in a slot when the timestep advances is discarded and counted.
module timeslot_event_scheduler #(
   parameter int NUM_SLOTS = 16,
   parameter int SLOT_W    = 4,
   parameter int ADDR_W    = 14,
   parameter int DEPTH     = 256,
   parameter int DEPTH_W   = 8,
   parameter int CNT_W     = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CLEAR,
   input  logic                 PUSH_VALID,
   input  logic [ADDR_W-1:0]    PUSH_ADDR,
   input  logic [SLOT_W-1:0]    PUSH_DELAY,
   output logic                 PUSH_FULL,
   input  logic                 POP_REQ,
   output logic                 POP_VALID,
   output logic [ADDR_W-1:0]    POP_DATA,
   input  logic                 ADVANCE,
   output logic [SLOT_W-1:0]    CUR_SLOT,
   output logic                 SLOT_EMPTY,
   output logic [DEPTH_W:0]     SLOT_COUNT,
   output logic [NUM_SLOTS-1:0] NONEMPTY_MAP,
   output logic                 ALL_EMPTY,
   output logic [CNT_W-1:0]     DROP_CNT,
   output logic [CNT_W-1:0]     FLUSH_CNT
);

   localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   // Wide enough that counter + largest residual cannot wrap before the clamp.
   localparam int SUM_W = ((CNT_W > DEPTH_W + 1) ? CNT_W : DEPTH_W + 1) + 1;

   logic [ADDR_W-1:0]  mem [NUM_SLOTS*DEPTH];

   logic [DEPTH_W-1:0] wr_ptr_q [NUM_SLOTS];
   logic [DEPTH_W-1:0] wr_ptr_d [NUM_SLOTS];
   logic [DEPTH_W-1:0] rd_ptr_q [NUM_SLOTS];
   logic [DEPTH_W-1:0] rd_ptr_d [NUM_SLOTS];
   logic [DEPTH_W:0]   count_q  [NUM_SLOTS];
   logic [DEPTH_W:0]   count_d  [NUM_SLOTS];
   logic [SLOT_W-1:0]  cur_slot_q, cur_slot_d;
   logic               pop_valid_q, pop_valid_d;
   logic [ADDR_W-1:0]  pop_data_q, pop_data_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

   logic [SLOT_W-1:0]  tgt_slot;
   logic               push_ok;
   logic               pop_ok;
   logic [SUM_W-1:0]   flush_sum;

   // Full and pop eligibility are judged on the pre-cycle counts only.
   always_comb begin
      tgt_slot  = cur_slot_q + PUSH_DELAY;
      PUSH_FULL = (count_q[tgt_slot] == FULL_CNT);
      push_ok   = PUSH_VALID && !PUSH_FULL;
      pop_ok    = POP_REQ && (count_q[cur_slot_q] != '0);
   end

   // Next-state: clear dominates; otherwise push, pop, then advance flush.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      cur_slot_d  = cur_slot_q;
      pop_valid_d = 1'b0;
      pop_data_d  = pop_data_q;
      drop_cnt_d  = drop_cnt_q;
      flush_cnt_d = flush_cnt_q;
      flush_sum   = '0;
      if (CLEAR) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            wr_ptr_d[s] = '0;
            rd_ptr_d[s] = '0;
            count_d[s]  = '0;
         end
         cur_slot_d = '0;
      end else begin
         if (pop_ok) begin
            pop_valid_d          = 1'b1;
            pop_data_d           = mem[{cur_slot_q, rd_ptr_q[cur_slot_q]}];
            rd_ptr_d[cur_slot_q] = rd_ptr_q[cur_slot_q] + DEPTH_W'(1);
            count_d[cur_slot_q]  = count_d[cur_slot_q] - (DEPTH_W + 1)'(1);
         end
         if (push_ok) begin
            wr_ptr_d[tgt_slot] = wr_ptr_q[tgt_slot] + DEPTH_W'(1);
            count_d[tgt_slot]  = count_d[tgt_slot] + (DEPTH_W + 1)'(1);
         end else if (PUSH_VALID && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
         end
         if (ADVANCE) begin
            // count_d of the old slot already includes this cycle's push/pop.
            flush_sum = SUM_W'(flush_cnt_q) + SUM_W'(count_d[cur_slot_q]);
            if (flush_sum > SUM_W'(CNT_MAX)) begin
               flush_cnt_d = CNT_MAX;
            end else begin
               flush_cnt_d = flush_sum[CNT_W-1:0];
            end
            rd_ptr_d[cur_slot_q] = wr_ptr_d[cur_slot_q];
            count_d[cur_slot_q]  = '0;
            cur_slot_d           = cur_slot_q + SLOT_W'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            wr_ptr_q[s] <= '0;
            rd_ptr_q[s] <= '0;
            count_q[s]  <= '0;
         end
         cur_slot_q  <= '0;
         pop_valid_q <= 1'b0;
         pop_data_q  <= '0;
         drop_cnt_q  <= '0;
         flush_cnt_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cur_slot_q  <= cur_slot_d;
         pop_valid_q <= pop_valid_d;
         pop_data_q  <= pop_data_d;
         drop_cnt_q  <= drop_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Event RAM write port; contents are never reset.
   always_ff @(posedge CLK) begin
      if (!RST && !CLEAR && push_ok) begin
         mem[{tgt_slot, wr_ptr_q[tgt_slot]}] <= PUSH_ADDR;
      end
   end

   // Status views derived from registered state.
   always_comb begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
         NONEMPTY_MAP[s] = (count_q[s] != '0);
      end
      ALL_EMPTY  = (NONEMPTY_MAP == '0);
      SLOT_COUNT = count_q[cur_slot_q];
      SLOT_EMPTY = (count_q[cur_slot_q] == '0);
      CUR_SLOT   = cur_slot_q;
      POP_VALID  = pop_valid_q;
      POP_DATA   = pop_data_q;
      DROP_CNT   = drop_cnt_q;
      FLUSH_CNT  = flush_cnt_q;
   end

endmodule

// File: tb/tb_timeslot_event_scheduler.sv
// Bench for timeslot_event_scheduler: a table of directed vectors, hand
// sequences for the multi-cycle corners, and a random run, all scored
// against a per-slot queue model.
module tb_timeslot_event_scheduler;

   localparam int NS    = 16;
   localparam int DEPTH = 256;
   localparam int CMAX  = 65535;

   logic        CLK = 1'b0;
   logic        RST, CLEAR, PUSH_VALID, POP_REQ, ADVANCE;
   logic [13:0] PUSH_ADDR;
   logic [3:0]  PUSH_DELAY;
   logic        PUSH_FULL, POP_VALID, SLOT_EMPTY, ALL_EMPTY;
   logic [13:0] POP_DATA;
   logic [3:0]  CUR_SLOT;
   logic [8:0]  SLOT_COUNT;
   logic [15:0] NONEMPTY_MAP, DROP_CNT, FLUSH_CNT;

   timeslot_event_scheduler dut (
      .CLK(CLK), .RST(RST), .CLEAR(CLEAR),
      .PUSH_VALID(PUSH_VALID), .PUSH_ADDR(PUSH_ADDR), .PUSH_DELAY(PUSH_DELAY),
      .PUSH_FULL(PUSH_FULL), .POP_REQ(POP_REQ), .POP_VALID(POP_VALID),
      .POP_DATA(POP_DATA), .ADVANCE(ADVANCE), .CUR_SLOT(CUR_SLOT),
      .SLOT_EMPTY(SLOT_EMPTY), .SLOT_COUNT(SLOT_COUNT),
      .NONEMPTY_MAP(NONEMPTY_MAP), .ALL_EMPTY(ALL_EMPTY),
      .DROP_CNT(DROP_CNT), .FLUSH_CNT(FLUSH_CNT)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // Reference model: one FIFO queue per slot plus scalar counters.
   logic [13:0] mq [NS][$];
   int          m_cur, m_drop, m_flush;
   bit          m_pv;
   logic [13:0] m_pd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NS; s++) mq[s].delete();
      m_cur = 0; m_drop = 0; m_flush = 0; m_pv = 0; m_pd = '0;
   endtask

   function automatic bit model_full(input logic [3:0] pd);
      return mq[(m_cur + int'(pd)) % NS].size() >= DEPTH;
   endfunction

   task automatic model_step(input bit clr, input bit pv, input logic [13:0] pa,
                             input logic [3:0] pd, input bit pr, input bit adv);
      int tgt;
      bit full, popok;
      if (clr) begin
         for (int s = 0; s < NS; s++) mq[s].delete();
         m_cur = 0; m_pv = 0;
         return;
      end
      tgt   = (m_cur + int'(pd)) % NS;
      full  = mq[tgt].size() >= DEPTH;
      popok = pr && (mq[m_cur].size() > 0);
      m_pv  = popok;
      if (popok) m_pd = mq[m_cur].pop_front();
      if (pv) begin
         if (full) m_drop = (m_drop >= CMAX) ? CMAX : m_drop + 1;
         else      mq[tgt].push_back(pa);
      end
      if (adv) begin
         m_flush = m_flush + mq[m_cur].size();
         if (m_flush > CMAX) m_flush = CMAX;
         mq[m_cur].delete();
         m_cur = (m_cur + 1) % NS;
      end
   endtask

   task automatic compare_all();
      logic [15:0] map;
      for (int s = 0; s < NS; s++) map[s] = (mq[s].size() != 0);
      chk("pop_valid", POP_VALID, m_pv);
      chk("pop_data", POP_DATA, m_pd);
      chk("cur_slot", CUR_SLOT, m_cur);
      chk("slot_count", SLOT_COUNT, mq[m_cur].size());
      chk("slot_empty", SLOT_EMPTY, mq[m_cur].size() == 0);
      chk("nonempty_map", NONEMPTY_MAP, map);
      chk("all_empty", ALL_EMPTY, map == 0);
      chk("drop_cnt", DROP_CNT, m_drop);
      chk("flush_cnt", FLUSH_CNT, m_flush);
   endtask

   // One clock cycle: drive, check PUSH_FULL, step the model, sample after edge.
   task automatic cyc(input bit clr, input bit pv, input logic [13:0] pa,
                      input logic [3:0] pd, input bit pr, input bit adv, input bit chk_on);
      CLEAR = clr; PUSH_VALID = pv; PUSH_ADDR = pa; PUSH_DELAY = pd;
      POP_REQ = pr; ADVANCE = adv;
      #1;
      if (chk_on) chk("push_full", PUSH_FULL, model_full(pd));
      model_step(clr, pv, pa, pd, pr, adv);
      @(posedge CLK); #1;
      if (chk_on) compare_all();
   endtask

   task automatic do_reset();
      RST = 1; CLEAR = 0; PUSH_VALID = 0; PUSH_ADDR = '0; PUSH_DELAY = '0;
      POP_REQ = 0; ADVANCE = 0;
      @(posedge CLK); #1;
      RST = 0;
      model_reset();
      compare_all();
   endtask

   typedef struct {
      bit          clr, pv;
      logic [13:0] pa;
      logic [3:0]  pd;
      bit          pr, adv;
      bit          e_valid;
      logic [13:0] e_data;
      logic [3:0]  e_cur;
      logic [8:0]  e_cnt;
      logic [15:0] e_map;
      logic [15:0] e_flush;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0,0,14'h000,4'd0, 0,0, 0,14'h000,4'd0,9'd0,16'h0000,16'd0};
      tbl[1]  = '{0,0,14'h000,4'd0, 1,0, 0,14'h000,4'd0,9'd0,16'h0000,16'd0};
      tbl[2]  = '{0,1,14'h011,4'd0, 0,0, 0,14'h000,4'd0,9'd1,16'h0001,16'd0};
      tbl[3]  = '{0,1,14'h022,4'd2, 0,0, 0,14'h000,4'd0,9'd1,16'h0005,16'd0};
      tbl[4]  = '{0,0,14'h000,4'd0, 1,0, 1,14'h011,4'd0,9'd0,16'h0004,16'd0};
      tbl[5]  = '{0,0,14'h000,4'd0, 0,1, 0,14'h011,4'd1,9'd0,16'h0004,16'd0};
      tbl[6]  = '{0,0,14'h000,4'd0, 0,1, 0,14'h011,4'd2,9'd1,16'h0004,16'd0};
      tbl[7]  = '{0,1,14'h033,4'd0, 1,0, 1,14'h022,4'd2,9'd1,16'h0004,16'd0};
      tbl[8]  = '{0,0,14'h000,4'd0, 1,1, 1,14'h033,4'd3,9'd0,16'h0000,16'd0};
      tbl[9]  = '{0,1,14'h044,4'd1, 0,1, 0,14'h033,4'd4,9'd1,16'h0010,16'd0};
      tbl[10] = '{0,1,14'h055,4'd0, 0,1, 0,14'h033,4'd5,9'd0,16'h0000,16'd2};
      tbl[11] = '{0,1,14'h066,4'd15,0,0, 0,14'h033,4'd5,9'd0,16'h0010,16'd2};

      // Directed vector table from reset.
      do_reset();
      chk("rst_cur", CUR_SLOT, 0);
      chk("rst_all_empty", ALL_EMPTY, 1);
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].clr, tbl[i].pv, tbl[i].pa, tbl[i].pd, tbl[i].pr, tbl[i].adv, 1);
         chk($sformatf("tbl%0d_valid", i), POP_VALID, tbl[i].e_valid);
         chk($sformatf("tbl%0d_data", i), POP_DATA, tbl[i].e_data);
         chk($sformatf("tbl%0d_cur", i), CUR_SLOT, tbl[i].e_cur);
         chk($sformatf("tbl%0d_cnt", i), SLOT_COUNT, tbl[i].e_cnt);
         chk($sformatf("tbl%0d_map", i), NONEMPTY_MAP, tbl[i].e_map);
         chk($sformatf("tbl%0d_flush", i), FLUSH_CNT, tbl[i].e_flush);
      end

      // Delayed push across the slot wrap.
      do_reset();
      for (int i = 0; i < 14; i++) cyc(0,0,0,0,0,1,1);
      chk("wrap_cur14", CUR_SLOT, 14);
      cyc(0,1,14'h0ABC,4'd3,0,0,1);
      chk("wrap_map_bit1", NONEMPTY_MAP, 16'h0002);
      cyc(0,0,0,0,0,1,1);
      chk("wrap_cur15", CUR_SLOT, 15);
      cyc(0,0,0,0,0,1,1);
      chk("wrap_cur0", CUR_SLOT, 0);
      cyc(0,0,0,0,0,1,1);
      chk("wrap_cur1", CUR_SLOT, 1);
      chk("wrap_count", SLOT_COUNT, 1);
      cyc(0,0,0,0,1,0,1);
      chk("wrap_pop_valid", POP_VALID, 1);
      chk("wrap_pop_data", POP_DATA, 14'h0ABC);

      // Fill past capacity, then pop+push on the full slot.
      do_reset();
      for (int i = 0; i < DEPTH + 2; i++) cyc(0,1,14'(16'h100 + i),4'd0,0,0,0);
      compare_all();
      chk("full_count", SLOT_COUNT, DEPTH);
      chk("full_drops", DROP_CNT, 2);
      PUSH_VALID = 0; PUSH_DELAY = 0; #1;
      chk("full_flag", PUSH_FULL, 1);
      cyc(0,1,14'h3FFF,4'd0,1,0,1);
      chk("full_pop_data", POP_DATA, 14'h100);
      chk("full_pop_drop", DROP_CNT, 3);
      chk("full_pop_count", SLOT_COUNT, DEPTH - 1);

      // Back-to-back pops then advance with a pop.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(0,1,14'(16'h200 + i),4'd0,0,0,1);
      cyc(0,0,0,0,1,0,1);
      chk("b2b_v0", POP_VALID, 1);
      chk("b2b_d0", POP_DATA, 14'h200);
      cyc(0,0,0,0,1,0,1);
      chk("b2b_v1", POP_VALID, 1);
      chk("b2b_d1", POP_DATA, 14'h201);
      cyc(0,0,0,0,1,1,1);
      chk("adv_pop_data", POP_DATA, 14'h202);
      chk("adv_flush", FLUSH_CNT, 2);
      chk("adv_old_empty", NONEMPTY_MAP, 16'h0000);

      // Several slots loaded, then CLEAR with a push in the same cycle.
      cyc(0,1,14'h071,4'd1,0,0,1);
      cyc(0,1,14'h072,4'd6,0,0,1);
      cyc(0,1,14'h073,4'd14,0,0,1);
      chk("pre_clear_map", NONEMPTY_MAP, 16'h8084);
      cyc(1,1,14'h155,4'd3,0,0,1);
      chk("clear_all_empty", ALL_EMPTY, 1);
      chk("clear_cur", CUR_SLOT, 0);
      chk("clear_flush_kept", FLUSH_CNT, 2);
      cyc(0,0,0,0,0,0,1);
      chk("clear_push_ignored", NONEMPTY_MAP, 16'h0000);

      // Drop counter saturation, then reset during a pop burst.
      do_reset();
      for (int i = 0; i < DEPTH + CMAX; i++) cyc(0,1,14'(i),4'd0,0,0,0);
      compare_all();
      chk("drop_sat", DROP_CNT, 16'hFFFF);
      cyc(0,1,14'h1,4'd0,0,0,1);
      chk("drop_sat_hold", DROP_CNT, 16'hFFFF);
      for (int i = 0; i < 3; i++) cyc(0,0,0,0,1,0,1);
      RST = 1; POP_REQ = 1;
      @(posedge CLK); #1;
      RST = 0; POP_REQ = 0;
      model_reset();
      compare_all();
      chk("rst_burst_valid", POP_VALID, 0);
      chk("rst_burst_count", SLOT_COUNT, 0);
      chk("rst_burst_drop", DROP_CNT, 0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         bit clr, pv, pr, adv;
         logic [3:0] pd;
         clr = ($urandom_range(0, 299) == 0);
         pv  = ($urandom_range(0, 9) < 7);
         pr  = ($urandom_range(0, 9) < 3);
         adv = ($urandom_range(0, 39) == 0);
         pd  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
         cyc(clr, pv, 14'($urandom), pd, pr, adv, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timeslot_event_scheduler.md
Name: timeslot_event_scheduler

Overview:
- Parametrised successor of the 16-slot spike scheduler.
- Holds one circular event queue per future timestep (slot). Each queue lives in a single shared RAM, indexed as slot*DEPTH + pointer.
- Events are pushed with a relative synaptic delay and popped from the current slot only.
- Adds behaviour the previous scheduler lacked:
  - timestep advance with residual-event flush
  - drop/flush accounting
  - bulk clear
  - per-slot occupancy map

Parameters:
- NUM_SLOTS, 16, number of timestep slots; power of two, at least 2.
- SLOT_W, 4, log2(NUM_SLOTS).
- ADDR_W, 14, event payload (neuron address) width.
- DEPTH, 256, entries per slot; power of two.
- DEPTH_W, 8, log2(DEPTH).
- CNT_W, 16, width of the saturating drop and flush counters.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- CLEAR  in  1  synchronous flush of all slots; CUR_SLOT returns to 0.
- PUSH_VALID  in  1  push request this cycle.
- PUSH_ADDR  in  ADDR_W  event payload.
- PUSH_DELAY  in  SLOT_W  relative delay; target slot = (CUR_SLOT + PUSH_DELAY) mod NUM_SLOTS.
- PUSH_FULL  out  1  combinational; the target slot of the current PUSH_DELAY is full.
- POP_REQ  in  1  pop the head of the current slot.
- POP_VALID  out  1  registered; POP_DATA is valid this cycle.
- POP_DATA  out  ADDR_W  registered popped payload.
- ADVANCE  in  1  end of timestep; move to the next slot.
- CUR_SLOT  out  SLOT_W  current timestep slot.
- SLOT_EMPTY  out  1  current slot count == 0.
- SLOT_COUNT  out  DEPTH_W+1  occupancy of the current slot.
- NONEMPTY_MAP  out  NUM_SLOTS  bit s set when count[s] != 0.
- ALL_EMPTY  out  1  NONEMPTY_MAP == 0.
- DROP_CNT  out  CNT_W  pushes discarded because the target slot was full; saturating.
- FLUSH_CNT  out  CNT_W  entries discarded by ADVANCE; saturating.

Behaviour:
- Reset (RST=1) values:
  - CUR_SLOT=0, POP_VALID=0, POP_DATA=0
  - all read/write pointers and counts 0
  - DROP_CNT=0, FLUSH_CNT=0
  - hence SLOT_EMPTY=1, ALL_EMPTY=1, NONEMPTY_MAP=0, SLOT_COUNT=0
  - RAM contents are not reset.
- Priority: RST > CLEAR > {push, pop, advance}.
- CLEAR:
  - zeroes all pointers and counts and sets CUR_SLOT=0.
  - POP_VALID=0 next cycle.
  - DROP_CNT and FLUSH_CNT are retained.
  - Cleared entries are not counted in FLUSH_CNT.
  - Any push, pop or advance in the same cycle is ignored.
- Push:
  - Target slot uses the pre-advance CUR_SLOT.
  - If count[target] < DEPTH: write RAM[target][wr_ptr], then wr_ptr+1 (wraps mod DEPTH) and count+1.
  - Otherwise the event is discarded and DROP_CNT increments (holds at 2^CNT_W-1).
  - There is no backpressure.
  - Full is evaluated on the pre-cycle count, so a push to a full slot is dropped even when a pop of that slot happens in the same cycle.
- Pop:
  - Accepted only when POP_REQ=1 and the pre-cycle count[CUR_SLOT] != 0. Otherwise it is ignored and POP_VALID=0.
  - Latency is 1: POP_VALID=1 and POP_DATA=head the cycle after acceptance. rd_ptr+1, count-1.
  - Back-to-back pops sustain one per cycle.
  - POP_DATA holds its value while POP_VALID=0.
- Push and pop on the same slot in one cycle: both take effect, net count unchanged. Addresses never collide, because the pop needs count >= 1.
- ADVANCE:
  - CUR_SLOT <= (CUR_SLOT+1) mod NUM_SLOTS; NUM_SLOTS-1 wraps to 0.
  - Leftover entries of the old slot are discarded: rd_ptr <= post-cycle wr_ptr, count <= 0.
  - FLUSH_CNT += residual, saturating, where residual = count_old + (push to old slot accepted) - (pop accepted).
  - A pop accepted in the advance cycle still returns data from the old slot.
- Slot indexing: all slot and pointer arithmetic is modulo and truncating, with no carries beyond SLOT_W / DEPTH_W bits.
- Status outputs are combinational from registered state:
  - SLOT_EMPTY, SLOT_COUNT, NONEMPTY_MAP, ALL_EMPTY, and PUSH_FULL (PUSH_FULL also depends on PUSH_DELAY).
  - They reflect the post-edge state one cycle after the causing event.

Test Plan:
- Reset then idle -> CUR_SLOT=0, ALL_EMPTY=1, DROP_CNT=0; POP_REQ on empty -> POP_VALID stays 0.
- Push 0x0ABC delay 3 with CUR_SLOT=14 -> NONEMPTY_MAP bit1 set. Two ADVANCEs pass (slot 15, then slot 0), then after the third ADVANCE CUR_SLOT=1 and a pop returns 0x0ABC one cycle after POP_REQ.
- Push DEPTH+2 events delay 0 -> SLOT_COUNT=DEPTH, DROP_CNT=2, PUSH_FULL=1. A simultaneous pop+push when full -> pop returns the first entry, push dropped, DROP_CNT=3.
- Load 5 events in the current slot, pop 2 back-to-back (data in order, POP_VALID two cycles), then ADVANCE with POP_REQ -> third entry returned, FLUSH_CNT=2, old slot count 0.
- Fill slots 2, 7, 15, then CLEAR with a simultaneous push -> ALL_EMPTY=1, CUR_SLOT=0, counters unchanged, push ignored.
- Force DROP_CNT to 0xFFFF via repeated full pushes -> stays 0xFFFF. Assert RST mid-pop burst -> POP_VALID=0 and all counts 0 the next cycle.
